// File: rtl/ex_stage_mc.sv
// Multi-cycle RISC-V execute stage: forwarding, ALU, branch compare and iterative RV32M/RV64M MDU.
// Latency: ALU ops and divide special cases take 1 cycle, other MDU ops take XLEN+1 cycles (accept to out_valid).
// Backpressure: in_ready drops while the MDU is busy or the output register is held by !out_ready.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   flush                            kills the accepted/in-flight op at the next edge
//   in_valid / in_ready              upstream handshake from the ID/EX register
//   data1, data2, pc_in, immediate_in operands from ID/EX
//   alu_result_mem, write_data_wb    forwarding sources from MEM and WB
//   alu_op, branch_jump              operation and branch/jump type
//   data*_sel_alu, data*_sel_bj      forwarding selects (0 rf, 1 pc/imm, 2 WB, 3 MEM)
//   out_valid / out_ready            downstream handshake to MEM
//   alu_result, store_data, pc_select registered results
module ex_stage_mc #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] immediate_in,
  input  logic [XLEN-1:0] alu_result_mem,
  input  logic [XLEN-1:0] write_data_wb,
  input  logic [4:0]      alu_op,
  input  logic [2:0]      branch_jump,
  input  logic [1:0]      data1_sel_alu,
  input  logic [1:0]      data2_sel_alu,
  input  logic [1:0]      data1_sel_bj,
  input  logic [1:0]      data2_sel_bj,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] store_data,
  output logic            pc_select
);

  localparam int SH_W = $clog2(XLEN);

  // ALU operation codes (alu_op[4:3] == 2'b11 is the MDU space)
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_SLL  = 5'd2;
  localparam logic [4:0] OP_SLT  = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;
  localparam logic [4:0] OP_PASSB = 5'd10; // LUI
  localparam logic [4:0] OP_LINK = 5'd11;  // a + 4, return address for jumps

  // Branch/jump types
  localparam logic [2:0] BJ_BEQ  = 3'd1;
  localparam logic [2:0] BJ_BNE  = 3'd2;
  localparam logic [2:0] BJ_BLT  = 3'd3;
  localparam logic [2:0] BJ_BGE  = 3'd4;
  localparam logic [2:0] BJ_BLTU = 3'd5;
  localparam logic [2:0] BJ_BGEU = 3'd6;
  localparam logic [2:0] BJ_JUMP = 3'd7;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   acc_q, acc_d;     // product high half / partial remainder
  logic [XLEN-1:0]   lo_q, lo_d;       // multiplier bits / dividend->quotient bits
  logic [XLEN-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;     // product/quotient sign
  logic              rneg_q, rneg_d;   // remainder sign follows the dividend
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   alu_result_q, alu_result_d;
  logic [XLEN-1:0]   store_data_q, store_data_d;
  logic              pc_select_q, pc_select_d;

  // ---------------- forwarding muxes ----------------
  logic [XLEN-1:0] alu_a, alu_b, bj_a, bj_b;

  always_comb begin
    case (data1_sel_alu)
      2'd0:    alu_a = data1;
      2'd1:    alu_a = pc_in;
      2'd2:    alu_a = write_data_wb;
      default: alu_a = alu_result_mem;
    endcase
    case (data2_sel_alu)
      2'd0:    alu_b = data2;
      2'd1:    alu_b = immediate_in;
      2'd2:    alu_b = write_data_wb;
      default: alu_b = alu_result_mem;
    endcase
    // Branch muxes have no PC/imm leg: select 1 falls back to the register file
    case (data1_sel_bj)
      2'd2:    bj_a = write_data_wb;
      2'd3:    bj_a = alu_result_mem;
      default: bj_a = data1;
    endcase
    case (data2_sel_bj)
      2'd2:    bj_b = write_data_wb;
      2'd3:    bj_b = alu_result_mem;
      default: bj_b = data2;
    endcase
  end

  // ---------------- single-cycle ALU ----------------
  logic [XLEN-1:0] alu_out;

  always_comb begin
    alu_out = '0;
    case (alu_op)
      OP_ADD:   alu_out = alu_a + alu_b;
      OP_SUB:   alu_out = alu_a - alu_b;
      OP_SLL:   alu_out = alu_a << alu_b[SH_W-1:0];
      OP_SLT:   alu_out = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      OP_SLTU:  alu_out = {{(XLEN-1){1'b0}}, alu_a < alu_b};
      OP_XOR:   alu_out = alu_a ^ alu_b;
      OP_SRL:   alu_out = alu_a >> alu_b[SH_W-1:0];
      OP_SRA:   alu_out = $signed(alu_a) >>> alu_b[SH_W-1:0];
      OP_OR:    alu_out = alu_a | alu_b;
      OP_AND:   alu_out = alu_a & alu_b;
      OP_PASSB: alu_out = alu_b;
      OP_LINK:  alu_out = alu_a + XLEN'(4);
      default:  alu_out = '0;
    endcase
  end

  // ---------------- branch logic ----------------
  logic br_taken;

  always_comb begin
    case (branch_jump)
      BJ_BEQ:  br_taken = (bj_a == bj_b);
      BJ_BNE:  br_taken = (bj_a != bj_b);
      BJ_BLT:  br_taken = ($signed(bj_a) <  $signed(bj_b));
      BJ_BGE:  br_taken = ($signed(bj_a) >= $signed(bj_b));
      BJ_BLTU: br_taken = (bj_a <  bj_b);
      BJ_BGEU: br_taken = (bj_a >= bj_b);
      BJ_JUMP: br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

  // ---------------- MDU operand preparation (accept cycle) ----------------
  logic            is_mdu, is_div, a_signed, b_signed, a_neg, b_neg;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  always_comb begin
    is_mdu   = (alu_op[4:3] == 2'b11);
    is_div   = alu_op[2];
    // DIV/REM are signed when funct3[0]==0; MULH signs both, MULHSU only rs1.
    // MUL needs no sign handling: the low half is sign-agnostic.
    a_signed = is_div ? ~alu_op[0] : ((alu_op[2:0] == 3'd1) || (alu_op[2:0] == 3'd2));
    b_signed = is_div ? ~alu_op[0] : (alu_op[2:0] == 3'd1);
    a_neg    = a_signed & alu_a[XLEN-1];
    b_neg    = b_signed & alu_b[XLEN-1];
    mag_a    = a_neg ? -alu_a : alu_a;
    mag_b    = b_neg ? -alu_b : alu_b;
    div_zero = is_div && (alu_b == '0);
    div_ovf  = is_div && !alu_op[0] && (alu_a == {1'b1, {(XLEN-1){1'b0}}}) && (alu_b == '1);
    // alu_op[1] distinguishes REM* from DIV*
    if (div_zero) special_res = alu_op[1] ? alu_a : '1;
    else          special_res = alu_op[1] ? '0    : alu_a;
  end

  // ---------------- MDU iteration step ----------------
  logic [XLEN:0]   mul_sum, div_sh, div_diff;
  logic [XLEN-1:0] step_acc, step_lo;

  always_comb begin
    mul_sum  = {1'b0, acc_q} + {1'b0, (lo_q[0] ? opnd_q : {XLEN{1'b0}})};
    div_sh   = {acc_q, lo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    if (f3_q[2]) begin
      // Restoring divide: keep the shifted remainder if the trial subtract borrowed
      if (!div_diff[XLEN]) begin
        step_acc = div_diff[XLEN-1:0];
        step_lo  = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        step_acc = div_sh[XLEN-1:0];
        step_lo  = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      // Shift-add multiply: the carry out of the add becomes the new MSB
      step_acc = mul_sum[XLEN:1];
      step_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // ---------------- MDU result fix-up ----------------
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, mdu_res;

  always_comb begin
    prod     = {step_acc, step_lo};
    prod_fix = neg_q  ? -prod     : prod;
    quo_fix  = neg_q  ? -step_lo  : step_lo;
    rem_fix  = rneg_q ? -step_acc : step_acc;
    case (f3_q)
      3'd0:       mdu_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:       mdu_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5: mdu_res = quo_fix;
      default:    mdu_res = rem_fix;
    endcase
  end

  // ---------------- control and next state ----------------
  logic accept, mdu_done;

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign mdu_done = (state_q == S_BUSY) && (cnt_q == CNT_W'(1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    lo_d         = lo_q;
    opnd_d       = opnd_q;
    f3_d         = f3_q;
    neg_d        = neg_q;
    rneg_d       = rneg_q;
    out_valid_d  = out_valid_q;
    alu_result_d = alu_result_q;
    store_data_d = store_data_q;
    pc_select_d  = pc_select_q;

    if (flush) begin
      // Kill takes priority over accept and completion in the same cycle
      state_d     = S_IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_ready) out_valid_d = 1'b0;

      if (state_q == S_BUSY) begin
        acc_d = step_acc;
        lo_d  = step_lo;
        cnt_d = cnt_q - CNT_W'(1);
      end

      if (accept) begin
        store_data_d = bj_b;
        pc_select_d  = is_mdu ? 1'b0 : br_taken;
        if (!is_mdu) begin
          alu_result_d = alu_out;
          out_valid_d  = 1'b1;
        end else if (div_zero || div_ovf) begin
          alu_result_d = special_res;
          out_valid_d  = 1'b1;
        end else begin
          state_d = S_BUSY;
          cnt_d   = CNT_W'(XLEN);
          acc_d   = '0;
          lo_d    = is_div ? mag_a : mag_b;
          opnd_d  = is_div ? mag_b : mag_a;
          f3_d    = alu_op[2:0];
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
        end
      end

      if (mdu_done) begin
        alu_result_d = mdu_res;
        out_valid_d  = 1'b1;
        state_d      = S_IDLE;
        cnt_d        = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      lo_q         <= '0;
      opnd_q       <= '0;
      f3_q         <= '0;
      neg_q        <= 1'b0;
      rneg_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      alu_result_q <= '0;
      store_data_q <= '0;
      pc_select_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      lo_q         <= lo_d;
      opnd_q       <= opnd_d;
      f3_q         <= f3_d;
      neg_q        <= neg_d;
      rneg_q       <= rneg_d;
      out_valid_q  <= out_valid_d;
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      pc_select_q  <= pc_select_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign alu_result = alu_result_q;
  assign store_data = store_data_q;
  assign pc_select  = pc_select_q;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed bench for ex_stage_mc: ALU forwarding/throughput, MDU results and latency,
// divide special cases, branch compare, output backpressure, flush and async reset.
module tb_ex_stage_mc;
  localparam int XLEN = 32;

  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1;
  localparam logic [4:0] MUL = 5'd24, MULH = 5'd25, MULHU = 5'd27;
  localparam logic [4:0] DIV = 5'd28, DIVU = 5'd29, REM = 5'd30, REMU = 5'd31;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] data1 = '0, data2 = '0, pc_in = '0, immediate_in = '0;
  logic [XLEN-1:0] alu_result_mem = '0, write_data_wb = '0;
  logic [4:0]      alu_op = '0;
  logic [2:0]      branch_jump = '0;
  logic [1:0]      data1_sel_alu = '0, data2_sel_alu = '0, data1_sel_bj = '0, data2_sel_bj = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] alu_result, store_data;
  logic            pc_select;

  int total = 0;
  int bad   = 0;

  ex_stage_mc #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .data1(data1), .data2(data2), .pc_in(pc_in), .immediate_in(immediate_in),
    .alu_result_mem(alu_result_mem), .write_data_wb(write_data_wb),
    .alu_op(alu_op), .branch_jump(branch_jump),
    .data1_sel_alu(data1_sel_alu), .data2_sel_alu(data2_sel_alu),
    .data1_sel_bj(data1_sel_bj), .data2_sel_bj(data2_sel_bj),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .store_data(store_data), .pc_select(pc_select)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [2:0] bj,
                       input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                       input logic [1:0] s1a, input logic [1:0] s2a,
                       input logic [1:0] s1b, input logic [1:0] s2b);
    in_valid      = 1'b1;
    alu_op        = op;
    branch_jump   = bj;
    data1         = d1;
    data2         = d2;
    data1_sel_alu = s1a;
    data2_sel_alu = s2a;
    data1_sel_bj  = s1b;
    data2_sel_bj  = s2b;
  endtask

  // Accept one MDU op, then count cycles until out_valid (accept cycle = 0).
  task automatic run_mdu(input string tag, input logic [4:0] op,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] exp, input int lat);
    int   n;
    logic rdy_seen;
    drive(op, 3'd0, a, b, 2'd0, 2'd0, 2'd0, 2'd0);
    step();
    in_valid = 1'b0;
    n        = 1;
    rdy_seen = 1'b0;
    while (!out_valid && n < 60) begin
      if (in_ready) rdy_seen = 1'b1;
      step();
      n++;
    end
    chk({tag, "_latency"}, XLEN'(n), XLEN'(lat));
    chk({tag, "_result"}, alu_result, exp);
    chk({tag, "_busy_rdy"}, XLEN'(rdy_seen), '0);
    step();
  endtask

  initial begin
    logic seen;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", XLEN'(out_valid), '0);
    chk("rst_alu_result", alu_result, '0);
    chk("rst_store_data", store_data, '0);
    chk("rst_pc_select", XLEN'(pc_select), '0);
    chk("rst_in_ready", XLEN'(in_ready), 32'd1);
    rst_n = 1'b1;

    // ---- ALU, back-to-back ----
    alu_result_mem = 32'd7;
    drive(ADD, 3'd0, 32'd5, 32'd0, 2'd0, 2'd3, 2'd0, 2'd0);
    #1;
    chk("add_in_ready", XLEN'(in_ready), 32'd1);
    step();
    chk("add_fwd_vld", XLEN'(out_valid), 32'd1);
    chk("add_fwd_res", alu_result, 32'd12);
    chk("add_pc_sel", XLEN'(pc_select), '0);
    drive(SUB, 3'd0, 32'd20, 32'd6, 2'd0, 2'd0, 2'd0, 2'd0);
    step();
    chk("sub_vld", XLEN'(out_valid), 32'd1);
    chk("sub_res", alu_result, 32'd14);
    pc_in        = 32'h100;
    immediate_in = 32'h10;
    drive(ADD, 3'd0, 32'd0, 32'd0, 2'd1, 2'd1, 2'd0, 2'd0);
    step();
    chk("pcimm_vld", XLEN'(out_valid), 32'd1);
    chk("pcimm_res", alu_result, 32'h110);
    in_valid = 1'b0;
    step();
    chk("drain_vld", XLEN'(out_valid), '0);

    // ---- MDU ----
    run_mdu("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_mdu("mul",   MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
    run_mdu("mulh",  MULH,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 33);
    run_mdu("div",   DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    run_mdu("rem",   REM,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    run_mdu("divu0", DIVU,  32'd100,       32'd0,         32'hFFFF_FFFF, 1);
    run_mdu("remu0", REMU,  32'd100,       32'd0,         32'd100,       1);
    run_mdu("divov", DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_mdu("remov", REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

    // ---- branches ----
    write_data_wb = 32'd9;
    drive(ADD, 3'd1, 32'd0, 32'd9, 2'd0, 2'd0, 2'd2, 2'd0);
    step();
    chk("beq_vld", XLEN'(out_valid), 32'd1);
    chk("beq_pc_sel", XLEN'(pc_select), 32'd1);
    chk("beq_store", store_data, 32'd9);
    drive(ADD, 3'd2, 32'd0, 32'd9, 2'd0, 2'd0, 2'd2, 2'd0);
    step();
    chk("bne_vld", XLEN'(out_valid), 32'd1);
    chk("bne_pc_sel", XLEN'(pc_select), '0);
    in_valid = 1'b0;
    step();

    // ---- output backpressure ----
    out_ready = 1'b0;
    drive(ADD, 3'd0, 32'd3, 32'd4, 2'd0, 2'd0, 2'd0, 2'd0);
    step();
    chk("bp_first_vld", XLEN'(out_valid), 32'd1);
    drive(ADD, 3'd0, 32'd1, 32'd1, 2'd0, 2'd0, 2'd0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_in_ready", XLEN'(in_ready), '0);
      chk("bp_hold_res", alu_result, 32'd7);
      chk("bp_hold_vld", XLEN'(out_valid), 32'd1);
      if (i < 3) step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", XLEN'(in_ready), 32'd1);
    step();
    chk("bp_next_vld", XLEN'(out_valid), 32'd1);
    chk("bp_next_res", alu_result, 32'd2);
    in_valid = 1'b0;
    step();
    chk("bp_drain_vld", XLEN'(out_valid), '0);

    // ---- flush during DIV ----
    drive(DIV, 3'd0, 32'd100, 32'd7, 2'd0, 2'd0, 2'd0, 2'd0);
    step();
    in_valid = 1'b0;
    repeat (9) step();
    chk("fl_busy_rdy", XLEN'(in_ready), '0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_in_ready", XLEN'(in_ready), 32'd1);
    chk("fl_out_vld", XLEN'(out_valid), '0);
    seen = 1'b0;
    repeat (40) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("fl_never_vld", XLEN'(seen), '0);
    drive(ADD, 3'd0, 32'd2, 32'd2, 2'd0, 2'd0, 2'd0, 2'd0);
    step();
    chk("fl_after_res", alu_result, 32'd4);
    in_valid = 1'b0;
    step();

    // ---- async reset mid-MUL ----
    drive(MULHU, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 2'd0, 2'd0, 2'd0);
    step();
    in_valid = 1'b0;
    repeat (5) step();
    chk("mr_store_cap", store_data, 32'hFFFF_FFFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_out_vld", XLEN'(out_valid), '0);
    chk("mr_alu_res", alu_result, '0);
    chk("mr_store", store_data, '0);
    chk("mr_pc_sel", XLEN'(pc_select), '0);
    chk("mr_in_ready", XLEN'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(ADD, 3'd0, 32'd8, 32'd9, 2'd0, 2'd0, 2'd0, 2'd0);
    step();
    chk("mr_first_vld", XLEN'(out_valid), 32'd1);
    chk("mr_first_res", alu_result, 32'd17);
    in_valid = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("mr_mul_killed", XLEN'(seen), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ex_stage_mc.md
# ex_stage_mc

Multi-cycle execute stage for the pipelined RISC-V core, generalised to XLEN bits, with registered EX/MEM outputs and a valid/ready handshake on both sides. It keeps the single-cycle ALU, branch compare and MEM/WB forwarding muxes. It adds an iterative RV32M/RV64M multiply/divide unit (MDU) that stalls the upstream stages while it runs. It sits between the ID/EX register and the MEM stage and replaces the purely combinational execute stage.

## Interface
- XLEN, 32: datapath width (32 or 64).
- CNT_W, $clog2(XLEN)+1: MDU iteration counter width (derived; do not override).

- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of the accepted/in-flight op (mispredict/trap).
- in_valid  in  1  ID/EX presents an op.
- in_ready  out  1  stage can accept this cycle.
- data1, data2  in  XLEN  register-file operands.
- pc_in, immediate_in  in  XLEN  PC and decoded immediate.
- alu_result_mem, write_data_wb  in  XLEN  forwarding sources.
- alu_op  in  5  op; alu_op[4:3]==2'b11 selects MDU with alu_op[2:0]=funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU); all other codes go to the existing ALU.
- branch_jump  in  3  branch/jump type for BranchLogic.
- data1_sel_alu, data2_sel_alu, data1_sel_bj, data2_sel_bj  in  2 each  forwarding selects: 0 regfile, 1 PC/imm (ALU muxes only; BJ muxes treat 1 as regfile), 2 WB, 3 MEM.
- out_valid  out  1  result register holds a valid op.
- out_ready  in  1  MEM accepts.
- alu_result  out  XLEN  registered ALU/MDU result.
- store_data  out  XLEN  registered forwarded rs2 (BJ data2 mux).
- pc_select  out  1  registered branch-taken; meaningful only with out_valid.

## Operation
- Accept = in_valid & in_ready. Forwarding muxes are resolved combinationally in the accept cycle. Resolved operands, op and store data are captured at that edge.
- in_ready = (state==IDLE) & (!out_valid | out_ready).
- ALU op: ALU and BranchLogic results load into the output register at the accept edge. out_valid=1 next cycle. Branch ops produce pc_select; pc_select=0 for non-branch ops.
- MDU op. State machine IDLE -> BUSY -> IDLE.
  - IDLE->BUSY on accept of an MDU op. Operands are converted to magnitudes per signedness (MULHSU: rs1 signed, rs2 unsigned). Counter is loaded with XLEN.
  - BUSY: one radix-2 step per cycle (shift-add multiply, restoring divide). Counter decrements each step.
  - At count 1, the final step completes. The sign is fixed up and the result is written to the output register: low XLEN for MUL, high XLEN for MULH*, quotient for DIV*, remainder for REM*. out_valid is set and state returns to IDLE.
- Special cases resolve in the accept edge, with no BUSY and ALU latency:
  - Divide by zero: quotient all-ones, remainder = dividend.
  - Signed overflow (dividend -2^(XLEN-1), divisor -1): quotient = dividend, remainder 0.
- Output register holds while out_valid & !out_ready. out_valid clears on out_ready when no new result loads that edge. Back-to-back ALU ops at full throughput.
- flush: state->IDLE and out_valid->0 at the next edge. flush wins over accept and completion in the same cycle. Any result in flight is discarded.
- Reset: state IDLE, counter 0, out_valid 0, alu_result 0, store_data 0, pc_select 0. in_ready is 1 after reset.

## Timing
- ALU latency: 1 cycle, accept edge to out_valid.
- MDU latency: XLEN+1 cycles from accept to out_valid (33 for XLEN=32). Special cases take 1 cycle.
- in_ready is 0 for the whole of BUSY and while the output is stalled.
- flush and out_ready are sampled every cycle, including in BUSY.
- Reset asserted mid-BUSY clears everything immediately. First accept is possible on the first edge after deassertion.

## Test plan
- ADD with data1=5 and data2 forwarded from alu_result_mem=7 (data2_sel_alu=3) -> next cycle out_valid=1, alu_result=12. Three back-to-back ops complete at one per cycle.
- MUL 0xFFFFFFFF*0xFFFFFFFF: MULHU -> 0xFFFFFFFE and MUL -> 0x00000001. MULH(-3, 5) -> 0xFFFFFFFF. Each out_valid appears exactly 33 cycles after accept, with in_ready=0 throughout.
- DIV -7/2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF. DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100 after 1 cycle. DIV 0x80000000/-1 -> 0x80000000 and REM -> 0.
- BEQ with data1_sel_bj=2 (write_data_wb=9) and data2=9 -> pc_select=1 with out_valid. BNE on the same operands -> pc_select=0.
- out_ready held 0 for 4 cycles after an ADD completes -> alu_result stable and in_ready=0. Release -> next op accepted the same cycle.
- flush in BUSY cycle 10 of a DIV -> next cycle in_ready=1 and out_valid never asserts for it. rst_n pulsed low mid-MUL -> all outputs 0 asynchronously.
